// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a valid/ready handshake and one-hot winner output.
// An unaccepted selection can optionally be held (locked) until the downstream accepts it.
module rr_onehot_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter bit          LOCK_IN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [NUM_REQ-1:0] sel_onehot_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2) begin : g_param_check
    $fatal(1, "rr_onehot_arbiter: NUM_REQ must be at least 2");
  end

  logic [PtrW-1:0]    rr_q, rr_d;
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] lock_sel_q, lock_sel_d;

  logic [NUM_REQ-1:0] prio_mask;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] pick_masked;
  logic [NUM_REQ-1:0] pick_unmasked;
  logic [NUM_REQ-1:0] arb_sel;
  logic [PtrW-1:0]    win_idx;
  logic               handshake;

  // Bits at or above the pointer get first pick; the unmasked search covers the wrap-around.
  always_comb begin
    prio_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      prio_mask[i] = (PtrW'(i) >= rr_q);
    end
  end

  assign req_masked    = req_i & prio_mask;
  assign pick_masked   = req_masked & (~req_masked + NUM_REQ'(1));
  assign pick_unmasked = req_i & (~req_i + NUM_REQ'(1));
  assign arb_sel       = (|req_masked) ? pick_masked : pick_unmasked;

  assign sel_onehot_o = lock_q ? lock_sel_q : arb_sel;
  assign valid_o      = lock_q | (|req_i);
  assign handshake    = valid_o & ready_i;
  assign gnt_o        = handshake ? sel_onehot_o : '0;

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_onehot_o[i]) begin
        win_idx = PtrW'(i);
      end
    end
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    if (flush_i) begin
      rr_d   = '0;
      lock_d = 1'b0;
    end else if (handshake) begin
      rr_d   = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + PtrW'(1);
      lock_d = 1'b0;
    end else if (valid_o && LOCK_IN) begin
      lock_d     = 1'b1;
      lock_sel_d = sel_onehot_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  a_sel_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(sel_onehot_o));
  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_gnt_needs_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|gnt_o) |-> ready_i);
  a_locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> (|(req_i & lock_sel_q)))
    else $error("locked requester dropped its request");

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter: a 4-requester locking instance and a
// 5-requester non-locking instance, both checked against a round-robin reference model.
module tb_rr_onehot_arbiter;

  localparam int N0 = 4;
  localparam int N1 = 5;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [N0-1:0] req0 = '0, gnt0, sel0;
  logic [N1-1:0] req1 = '0, gnt1, sel1;
  logic          valid0, valid1;

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.NUM_REQ(N0), .LOCK_IN(1'b1)) u_dut0 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_i       (req0),
    .gnt_o       (gnt0),
    .valid_o     (valid0),
    .ready_i     (ready_i),
    .sel_onehot_o(sel0)
  );

  rr_onehot_arbiter #(.NUM_REQ(N1), .LOCK_IN(1'b0)) u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_i       (req1),
    .gnt_o       (gnt1),
    .valid_o     (valid1),
    .ready_i     (ready_i),
    .sel_onehot_o(sel1)
  );

  typedef struct packed {
    logic       valid;
    logic [7:0] sel;
    logic [7:0] gnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc_n = 0;

  // Reference model state: priority index, lock flag, locked index.
  int   nreq[2]   = '{N0, N1};
  bit   lockin[2] = '{1'b1, 1'b0};
  int   m_rr[2]   = '{0, 0};
  bit   m_lock[2] = '{1'b0, 1'b0};
  int   m_lidx[2] = '{0, 0};

  function automatic int winner(int n, int rr, logic [7:0] req);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (rr + k) % n;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic int presented(int d, logic [7:0] req);
    return m_lock[d] ? m_lidx[d] : winner(nreq[d], m_rr[d], req);
  endfunction

  function automatic exp_t expect_of(int d, logic [7:0] req, logic rdy);
    exp_t e;
    int   idx;
    idx     = presented(d, req);
    e.valid = (idx >= 0);
    e.sel   = (idx >= 0) ? (8'd1 << idx) : 8'd0;
    e.gnt   = rdy ? e.sel : 8'd0;
    return e;
  endfunction

  task automatic model_step(int d, logic [7:0] req, logic rdy, logic fl);
    int idx;
    idx = presented(d, req);
    if (fl) begin
      m_rr[d]   = 0;
      m_lock[d] = 1'b0;
    end else if (idx >= 0 && rdy) begin
      m_rr[d]   = (idx + 1) % nreq[d];
      m_lock[d] = 1'b0;
    end else if (idx >= 0 && lockin[d]) begin
      m_lock[d] = 1'b1;
      m_lidx[d] = idx;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rr[d]   = 0;
      m_lock[d] = 1'b0;
      m_lidx[d] = 0;
    end
  endtask

  // One clock cycle: advance the model over the edge, then apply new inputs and queue expectations.
  task automatic cyc(logic [7:0] r0, logic [7:0] r1, logic rdy, logic fl, logic rst);
    @(posedge clk);
    if (rst_ni) begin
      model_step(0, 8'(req0), ready_i, flush_i);
      model_step(1, 8'(req1), ready_i, flush_i);
    end
    #1;
    rst_ni = rst;
    if (!rst) model_reset();
    if (m_lock[0]) r0[m_lidx[0]] = 1'b1;
    req0    = r0[N0-1:0];
    req1    = r1[N1-1:0];
    ready_i = rdy;
    flush_i = fl;
    q0.push_back(expect_of(0, 8'(req0), rdy));
    q1.push_back(expect_of(1, 8'(req1), rdy));
  endtask

  task automatic check(string name, logic v, logic [7:0] s, logic [7:0] g, exp_t e);
    n_checks++;
    if (v === e.valid && s === e.sel && g === e.gnt) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got valid=%b sel=%b gnt=%b, expected valid=%b sel=%b gnt=%b",
               name, cyc_n, v, s, g, e.valid, e.sel, e.gnt);
    end
  endtask

  always @(negedge clk) begin
    cyc_n++;
    if (q0.size() > 0) check("dut0_n4_lock", valid0, 8'(sel0), 8'(gnt0), q0.pop_front());
    if (q1.size() > 0) check("dut1_n5_nolock", valid1, 8'(sel1), 8'(gnt1), q1.pop_front());
  end

  initial begin
    // Reset with no requests, then release with req=0100 and ready.
    cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(8'h04, 8'h04, 1'b1, 1'b0, 1'b1);
    // Skip and wrap from pointer 3.
    cyc(8'h03, 8'h03, 1'b1, 1'b0, 1'b1);
    cyc(8'h03, 8'h03, 1'b1, 1'b0, 1'b1);
    // Fairness from a flushed pointer.
    cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(8'h0f, 8'h1f, 1'b1, 1'b0, 1'b1);
    // Lock then accept.
    cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    cyc(8'h06, 8'h06, 1'b0, 1'b0, 1'b1);
    cyc(8'h07, 8'h07, 1'b0, 1'b0, 1'b1);
    cyc(8'h07, 8'h07, 1'b0, 1'b0, 1'b1);
    cyc(8'h07, 8'h07, 1'b1, 1'b0, 1'b1);
    cyc(8'h07, 8'h07, 1'b0, 1'b0, 1'b1);
    // Non-locking re-evaluation: pointer at 2, then a request appears at 2.
    cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    cyc(8'h02, 8'h02, 1'b1, 1'b0, 1'b1);
    cyc(8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
    cyc(8'h06, 8'h06, 1'b0, 1'b0, 1'b1);
    // Flush mid-lock, flush racing a handshake.
    cyc(8'h08, 8'h08, 1'b0, 1'b0, 1'b1);
    cyc(8'h08, 8'h08, 1'b0, 1'b1, 1'b1);
    cyc(8'h09, 8'h09, 1'b0, 1'b0, 1'b1);
    cyc(8'h0c, 8'h0c, 1'b1, 1'b1, 1'b1);
    cyc(8'h0c, 8'h0c, 1'b1, 1'b0, 1'b1);
    // Async reset mid-lock, then top index wrap for the 5-wide instance.
    cyc(8'h08, 8'h08, 1'b0, 1'b0, 1'b1);
    cyc(8'h0a, 8'h0a, 1'b0, 1'b0, 1'b0);
    cyc(8'h0a, 8'h0a, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 8'h10, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 8'h1f, 1'b1, 1'b0, 1'b1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) != 0));
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q0.size() == 0 && q1.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
